// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the GPIO AXI4-Lite front end: arbiter FSM state
// encodings, AXI response codes and the GPIO register map.
package gpio_ctrl_pkg;

   // Arbiter FSM state encodings
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR      = 3'd1;
   localparam logic [2:0] ST_WR_RESP = 3'd2;
   localparam logic [2:0] ST_RD_ADDR = 3'd3;
   localparam logic [2:0] ST_RD_DATA = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   // AXI response codes
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   // GPIO register offsets (9-bit slave address space)
   localparam logic [8:0] GPIO_DATA  = 9'h000;
   localparam logic [8:0] GPIO_TRI   = 9'h004;
   localparam logic [8:0] GPIO2_DATA = 9'h008;
   localparam logic [8:0] GPIO2_TRI  = 9'h00C;

endpackage

// File: rtl/gpio_axil_arbiter_rr.sv
// Round-robin arbiter: one-hot grant of the first requester at or after the
// priority pointer. The pointer moves past the winner only when the grant is
// actually taken (advance), so idle cycles do not disturb fairness.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   logic [IDX_W-1:0] ptr_r;
   int               cand_s;

   // Search from the pointer, wrapping, for the first active request
   always_comb begin
      grant       = {NUM_REQ{1'b0}};
      grant_idx   = {IDX_W{1'b0}};
      grant_valid = 1'b0;
      cand_s      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_s = (int'(ptr_r) + i) % NUM_REQ;
         if (!grant_valid && req[cand_s]) begin
            grant_valid    = 1'b1;
            grant_idx      = IDX_W'(cand_s);
            grant[cand_s]  = 1'b1;
         end else begin
            grant_valid    = grant_valid;
         end
      end
   end

   // Priority pointer moves to the requester after the one just granted
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r <= {IDX_W{1'b0}};
      end else if (advance && grant_valid) begin
         if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
            ptr_r <= {IDX_W{1'b0}};
         end else begin
            ptr_r <= grant_idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/gpio_axil_arbiter.sv
// Shares the GPIO AXI4-Lite slave port between NUM_REQ requesters. One
// single-beat command is in flight at a time; all m_axi valid/ready outputs
// come straight from flops.
module gpio_axil_arbiter
   import gpio_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic [1:0]                       rsp_resp,
   output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
   output logic                             m_axi_awvalid,
   input  logic                             m_axi_awready,
   output logic [DATA_WIDTH-1:0]            m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]          m_axi_wstrb,
   output logic                             m_axi_wvalid,
   input  logic                             m_axi_wready,
   input  logic [1:0]                       m_axi_bresp,
   input  logic                             m_axi_bvalid,
   output logic                             m_axi_bready,
   output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
   output logic                             m_axi_arvalid,
   input  logic                             m_axi_arready,
   input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
   input  logic [1:0]                       m_axi_rresp,
   input  logic                             m_axi_rvalid,
   output logic                             m_axi_rready
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [2:0]            state_r;
   logic [NUM_REQ-1:0]    owner_r;
   logic                  awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
   logic [ADDR_WIDTH-1:0] awaddr_r, araddr_r;
   logic [DATA_WIDTH-1:0] wdata_r, rsp_rdata_r;
   logic [1:0]            rsp_resp_r;
   logic [NUM_REQ-1:0]    rsp_valid_r;

   logic [NUM_REQ-1:0]    grant_s;
   logic [IDX_W-1:0]      grant_idx_s;
   logic                  grant_valid_s;
   logic                  advance_s;
   logic                  sel_write_s;
   logic [ADDR_WIDTH-1:0] sel_addr_s;
   logic [DATA_WIDTH-1:0] sel_wdata_s;
   logic                  aw_done_s, w_done_s;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .clk         (clk),
      .reset       (reset),
      .req         (req_valid),
      .advance     (advance_s),
      .grant       (grant_s),
      .grant_idx   (grant_idx_s),
      .grant_valid (grant_valid_s)
   );

   // Accept a command only while idle; select the winner's command fields
   always_comb begin
      if (state_r == ST_IDLE) begin
         advance_s = grant_valid_s;
      end else begin
         advance_s = 1'b0;
      end
      if (advance_s) begin
         req_ready = grant_s;
      end else begin
         req_ready = {NUM_REQ{1'b0}};
      end
      sel_write_s = req_write[grant_idx_s];
      sel_addr_s  = req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
      sel_wdata_s = req_wdata[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
      // A write channel is finished once its valid is low or handshakes now
      aw_done_s   = !awvalid_r || m_axi_awready;
      w_done_s    = !wvalid_r  || m_axi_wready;
   end

   // Transaction sequencer: grant, drive AXI channels, capture response
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         owner_r     <= {NUM_REQ{1'b0}};
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         arvalid_r   <= 1'b0;
         rready_r    <= 1'b0;
         awaddr_r    <= {ADDR_WIDTH{1'b0}};
         araddr_r    <= {ADDR_WIDTH{1'b0}};
         wdata_r     <= {DATA_WIDTH{1'b0}};
         rsp_rdata_r <= {DATA_WIDTH{1'b0}};
         rsp_resp_r  <= AXI_RESP_OKAY;
         rsp_valid_r <= {NUM_REQ{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (advance_s) begin
                  owner_r <= grant_s;
                  if (sel_write_s) begin
                     awaddr_r  <= sel_addr_s;
                     wdata_r   <= sel_wdata_s;
                     awvalid_r <= 1'b1;
                     wvalid_r  <= 1'b1;
                     state_r   <= ST_WR;
                  end else begin
                     araddr_r  <= sel_addr_s;
                     arvalid_r <= 1'b1;
                     state_r   <= ST_RD_ADDR;
                  end
               end
            end
            ST_WR: begin
               if (awvalid_r && m_axi_awready) begin
                  awvalid_r <= 1'b0;
               end
               if (wvalid_r && m_axi_wready) begin
                  wvalid_r <= 1'b0;
               end
               if (aw_done_s && w_done_s) begin
                  bready_r <= 1'b1;
                  state_r  <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (m_axi_bvalid) begin
                  bready_r    <= 1'b0;
                  rsp_resp_r  <= m_axi_bresp;
                  rsp_rdata_r <= {DATA_WIDTH{1'b0}};
                  rsp_valid_r <= owner_r;
                  state_r     <= ST_DONE;
               end
            end
            ST_RD_ADDR: begin
               if (m_axi_arready) begin
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
                  state_r   <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (m_axi_rvalid) begin
                  rready_r    <= 1'b0;
                  rsp_rdata_r <= m_axi_rdata;
                  rsp_resp_r  <= m_axi_rresp;
                  rsp_valid_r <= owner_r;
                  state_r     <= ST_DONE;
               end
            end
            ST_DONE: begin
               rsp_valid_r <= {NUM_REQ{1'b0}};
               state_r     <= ST_IDLE;
            end
            default: begin
               awvalid_r   <= 1'b0;
               wvalid_r    <= 1'b0;
               bready_r    <= 1'b0;
               arvalid_r   <= 1'b0;
               rready_r    <= 1'b0;
               rsp_valid_r <= {NUM_REQ{1'b0}};
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_axi_awaddr  = awaddr_r;
   assign m_axi_awvalid = awvalid_r;
   assign m_axi_wdata   = wdata_r;
   assign m_axi_wstrb   = {(DATA_WIDTH/8){1'b1}};
   assign m_axi_wvalid  = wvalid_r;
   assign m_axi_bready  = bready_r;
   assign m_axi_araddr  = araddr_r;
   assign m_axi_arvalid = arvalid_r;
   assign m_axi_rready  = rready_r;
   assign rsp_valid     = rsp_valid_r;
   assign rsp_rdata     = rsp_rdata_r;
   assign rsp_resp      = rsp_resp_r;

endmodule

// File: tb/tb_gpio_axil_arbiter.sv
// Directed bench for gpio_axil_arbiter with a small AXI4-Lite slave model
// whose per-channel ready/valid delays and response codes are programmable.
module tb_gpio_axil_arbiter;
   import gpio_ctrl_pkg::*;

   localparam int NR = 2;
   localparam int AW = 9;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    req_valid, req_ready, req_write, rsp_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [DW-1:0]    rsp_rdata;
   logic [1:0]       rsp_resp;
   logic [AW-1:0]    m_axi_awaddr, m_axi_araddr;
   logic             m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [DW-1:0]    m_axi_wdata, m_axi_rdata;
   logic [DW/8-1:0]  m_axi_wstrb;
   logic [1:0]       m_axi_bresp, m_axi_rresp;
   logic             m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic             m_axi_rvalid, m_axi_rready;

   int n_tests = 0;
   int n_fail  = 0;

   // slave configuration and state
   int         aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
   logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
   int         aw_cnt, w_cnt, ar_cnt, r_cnt;
   logic       got_aw, got_w, got_ar;
   logic [AW-1:0] aw_addr_q, ar_addr_q;
   logic [DW-1:0] w_data_q;
   logic [DW-1:0] mem [0:127];

   // activity tallies
   int b_hs = 0, ar_hs = 0, aw_hi = 0, w_hi = 0, rready_hi = 0, rready_gap = 0, rsp_cnt = 0;
   int grant_log[$];

   always #5 clk = ~clk;

   gpio_axil_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   // slave: ready after N cycles of valid; B/R valid once the request is held
   assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_delay);
   assign m_axi_wready  = m_axi_wvalid  && (w_cnt  >= w_delay);
   assign m_axi_bvalid  = got_aw && got_w;
   assign m_axi_bresp   = b_resp_cfg;
   assign m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_delay);
   assign m_axi_rvalid  = got_ar && (r_cnt >= r_delay);
   assign m_axi_rdata   = m_axi_rvalid ? mem[ar_addr_q[8:2]] : 32'h0;
   assign m_axi_rresp   = r_resp_cfg;

   // slave sequential state
   always @(posedge clk) begin
      if (reset) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
         got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
      end else begin
         if (m_axi_awvalid && !m_axi_awready) aw_cnt <= aw_cnt + 1; else aw_cnt <= 0;
         if (m_axi_wvalid && !m_axi_wready) w_cnt <= w_cnt + 1; else w_cnt <= 0;
         if (m_axi_arvalid && !m_axi_arready) ar_cnt <= ar_cnt + 1; else ar_cnt <= 0;
         if (m_axi_awvalid && m_axi_awready) begin
            got_aw <= 1'b1; aw_addr_q <= m_axi_awaddr;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            got_w <= 1'b1; w_data_q <= m_axi_wdata;
         end
         if (m_axi_bvalid && m_axi_bready) begin
            got_aw <= 1'b0; got_w <= 1'b0; b_hs <= b_hs + 1;
            mem[aw_addr_q[8:2]] <= w_data_q;
         end
         if (m_axi_arvalid && m_axi_arready) begin
            got_ar <= 1'b1; ar_addr_q <= m_axi_araddr; ar_hs <= ar_hs + 1;
         end
         if (got_ar && !m_axi_rvalid) r_cnt <= r_cnt + 1;
         else if (!got_ar) r_cnt <= 0;
         if (m_axi_rvalid && m_axi_rready) got_ar <= 1'b0;
      end
   end

   // activity monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (m_axi_awvalid) aw_hi <= aw_hi + 1;
      if (m_axi_wvalid) w_hi <= w_hi + 1;
      if (m_axi_rready) rready_hi <= rready_hi + 1;
      if (got_ar && !m_axi_rready) rready_gap <= rready_gap + 1;
      if (rsp_valid != 2'b00) rsp_cnt <= rsp_cnt + 1;
      if (req_ready != 2'b00) grant_log.push_back((req_ready == 2'b01) ? 0 : ((req_ready == 2'b10) ? 1 : 99));
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // issue one command from requester r and wait (bounded) for its completion
   task automatic do_cmd(input int r, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         output logic [DW-1:0] rdata, output logic [1:0] resp,
                         output logic [NR-1:0] rspv, output int lat);
      int n;
      req_write[r] = wr;
      req_addr[r*AW +: AW] = addr;
      req_wdata[r*DW +: DW] = data;
      req_valid[r] = 1'b1;
      #1;
      n = 0;
      while (!req_ready[r] && n < 50) begin
         step();
         n++;
      end
      check_eq("accept", {63'd0, req_ready[r]}, 64'd1);
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
      lat = 0;
      do begin
         step();
         lat++;
      end while (rsp_valid == 2'b00 && lat < 100);
      rspv  = rsp_valid;
      rdata = rsp_rdata;
      resp  = rsp_resp;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] rd;
      logic [1:0]    rs;
      logic [NR-1:0] rv;
      int lat, s_aw, s_w, s_b, s_ar, s_rh, s_rg, s_rsp, start, n, g;

      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      reset = 1'b1;
      req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      step();

      // reset state
      check_eq("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'd0);
      check_eq("rst_handshake", {req_ready, rsp_valid}, 64'd0);
      check_eq("rst_addr", {m_axi_awaddr, m_axi_araddr}, 64'd0);
      check_eq("rst_data", {m_axi_wdata, rsp_rdata}, 64'd0);
      check_eq("rst_resp", rsp_resp, 64'd0);

      // T1: req0 writes 0x39AF1292 to GPIO_TRI, cycle-exact with zero-wait slave
      req_write[0] = 1'b1; req_addr[8:0] = GPIO_TRI; req_wdata[31:0] = 32'h39AF1292; req_valid[0] = 1'b1;
      #1;
      check_eq("t1_ready", req_ready, 64'h1);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      step();
      check_eq("t1_awv_wv", {m_axi_awvalid, m_axi_wvalid}, 64'h3);
      check_eq("t1_awaddr", m_axi_awaddr, 64'h004);
      check_eq("t1_wstrb", m_axi_wstrb, 64'hF);
      check_eq("t1_wdata", m_axi_wdata, 64'h39AF1292);
      step();
      check_eq("t1_bready", {m_axi_bready, m_axi_awvalid, m_axi_wvalid}, 64'h4);
      step();
      check_eq("t1_rsp_valid", rsp_valid, 64'h1);
      check_eq("t1_rsp_resp", rsp_resp, 64'h0);
      check_eq("t1_rsp_rdata", rsp_rdata, 64'h0);
      step();
      check_eq("t1_rsp_pulse", rsp_valid, 64'h0);

      // T2: req1 reads back GPIO_TRI
      do_cmd(1, 1'b0, GPIO_TRI, 32'h0, rd, rs, rv, lat);
      check_eq("t2_rsp_valid", rv, 64'h2);
      check_eq("t2_araddr", ar_addr_q, 64'h004);
      check_eq("t2_rdata", rd, 64'h39AF1292);
      check_eq("t2_resp", rs, 64'h0);
      check_eq("t2_latency", lat, 64'd3);

      // T3: both requesters held for four reads -> strict alternation 0,1,0,1
      start = grant_log.size(); s_rsp = rsp_cnt;
      req_write = 2'b00; req_addr = {GPIO_TRI, GPIO_TRI}; req_valid = 2'b11;
      n = 0;
      while (grant_log.size() < start + 4 && n < 200) begin
         step();
         n++;
      end
      @(posedge clk); #1 req_valid = 2'b00;
      repeat (6) step();
      check_eq("t3_grants", grant_log.size() - start, 64'd4);
      for (int k = 0; k < 4; k++) begin
         g = (start + k < grant_log.size()) ? grant_log[start + k] : -1;
         check_eq($sformatf("t3_order%0d", k), g, k % 2);
      end
      check_eq("t3_rsp_count", rsp_cnt - s_rsp, 64'd4);

      // T4a: awready immediately, wready 3 cycles later
      aw_delay = 0; w_delay = 3;
      s_aw = aw_hi; s_w = w_hi; s_b = b_hs; s_rsp = rsp_cnt;
      do_cmd(0, 1'b1, GPIO2_DATA, 32'hA5A50001, rd, rs, rv, lat);
      step();
      check_eq("t4a_rsp_valid", rv, 64'h1);
      check_eq("t4a_rdata_zero", rd, 64'h0);
      check_eq("t4a_resp", rs, 64'h0);
      check_eq("t4a_aw_cycles", aw_hi - s_aw, 64'd1);
      check_eq("t4a_w_cycles", w_hi - s_w, 64'd4);
      check_eq("t4a_b_hs", b_hs - s_b, 64'd1);
      check_eq("t4a_rsp_count", rsp_cnt - s_rsp, 64'd1);
      check_eq("t4a_latency", lat, 64'd6);

      // T4b: wready immediately, awready 3 cycles later
      aw_delay = 3; w_delay = 0;
      s_aw = aw_hi; s_w = w_hi; s_b = b_hs; s_rsp = rsp_cnt;
      do_cmd(1, 1'b1, GPIO2_TRI, 32'h00005A5A, rd, rs, rv, lat);
      step();
      check_eq("t4b_rsp_valid", rv, 64'h2);
      check_eq("t4b_aw_cycles", aw_hi - s_aw, 64'd4);
      check_eq("t4b_w_cycles", w_hi - s_w, 64'd1);
      check_eq("t4b_b_hs", b_hs - s_b, 64'd1);
      check_eq("t4b_rsp_count", rsp_cnt - s_rsp, 64'd1);
      check_eq("t4b_mem", mem[3], 64'h5A5A);
      aw_delay = 0;

      // T5: rvalid delayed 10 cycles with SLVERR
      r_delay = 10; r_resp_cfg = AXI_RESP_SLVERR;
      s_ar = ar_hs; s_rh = rready_hi; s_rg = rready_gap;
      do_cmd(0, 1'b0, GPIO_TRI, 32'h0, rd, rs, rv, lat);
      repeat (4) step();
      check_eq("t5_rsp_valid", rv, 64'h1);
      check_eq("t5_resp", rs, 64'h2);
      check_eq("t5_rdata", rd, 64'h39AF1292);
      check_eq("t5_ar_once", ar_hs - s_ar, 64'd1);
      check_eq("t5_rready_cycles", rready_hi - s_rh, 64'd11);
      check_eq("t5_rready_gap", rready_gap - s_rg, 64'd0);
      check_eq("t5_latency", lat, 64'd13);
      r_delay = 0; r_resp_cfg = AXI_RESP_OKAY;

      // T6: reset one cycle after awvalid rises
      aw_delay = 5; w_delay = 5;
      req_write[0] = 1'b1; req_addr[8:0] = GPIO_DATA; req_wdata[31:0] = 32'h00001234; req_valid[0] = 1'b1;
      #1;
      check_eq("t6_ready", req_ready, 64'h1);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      step();
      check_eq("t6_awvalid_up", m_axi_awvalid, 64'h1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      step();
      check_eq("t6_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'd0);
      check_eq("t6_rsp_valid", rsp_valid, 64'h0);
      check_eq("t6_awaddr", {m_axi_awaddr, m_axi_wdata}, 64'h0);
      s_rsp = rsp_cnt;
      repeat (6) step();
      check_eq("t6_no_rsp", rsp_cnt - s_rsp, 64'd0);
      aw_delay = 0; w_delay = 0;
      req_write = 2'b00; req_addr = {GPIO_TRI, GPIO_TRI}; req_valid = 2'b11;
      #1;
      check_eq("t6_first_grant", req_ready, 64'h1);
      @(posedge clk); #1 req_valid = 2'b00;
      n = 0;
      while (rsp_cnt == s_rsp && n < 50) begin
         step();
         n++;
      end
      check_eq("t6_after_rsp", rsp_cnt - s_rsp, 64'd1);
      repeat (2) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_axil_arbiter.md
Name: gpio_axil_arbiter

Overview:
Shares the single AXI4-Lite slave port of the GPIO block between NUM_REQ register-access requesters (e.g. test sequencer and interrupt service engine). Arbitrates round-robin, accepts one single-beat read or write command at a time, and sequences the AXI-Lite master channels. Returns read data and response to the granted requester. Sits directly in front of the GPIO s_axi_* port; one transaction is outstanding at a time.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 9, AXI-Lite address width; matches the GPIO slave
DATA_WIDTH, 32, AXI-Lite data width; wstrb width = DATA_WIDTH/8

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester command valid; held until matching req_ready
req_ready  out  NUM_REQ  one-hot, one-cycle command-accept pulse
req_write  in  NUM_REQ  1 = write, 0 = read, per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data of last completed read; write completion returns 0
rsp_resp  out  2  BRESP/RRESP of last completed transaction
m_axi_awaddr  out  ADDR_WIDTH
m_axi_awvalid  out  1
m_axi_awready  in  1
m_axi_wdata  out  DATA_WIDTH
m_axi_wstrb  out  DATA_WIDTH/8  always all ones
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1
m_axi_araddr  out  ADDR_WIDTH
m_axi_arvalid  out  1
m_axi_arready  in  1
m_axi_rdata  in  DATA_WIDTH
m_axi_rresp  in  2
m_axi_rvalid  in  1
m_axi_rready  out  1

Behaviour:
- Reset (synchronous, active-high): state IDLE; all valid/ready outputs 0; awaddr/araddr/wdata/rsp_rdata/rsp_resp 0; priority pointer = requester 0.
- Reset mid-transaction: aborts immediately. The next cycle shows all outputs at reset values. No rsp_valid is issued for the aborted command. The slave is reset by the same system reset.
- States: IDLE, WR (aw+w), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - If any req_valid, grant the first asserted index at or after the pointer, wrapping modulo NUM_REQ.
  - Pulse req_ready[grant] and register write/addr/wdata.
  - Next state: WR if write, else RD_ADDR.
  - Pointer moves to grant+1 (mod NUM_REQ) at grant time.
  - Idle cycles with no request leave the pointer unchanged.
- WR: awvalid and wvalid both assert the cycle after the grant.
  - Each valid deasserts independently on the cycle after its own handshake (valid & ready at an edge).
  - Go to WR_RESP once both have completed, in either order or simultaneously.
- WR_RESP: bready = 1; on bvalid, capture bresp, set rsp_rdata = 0, go to DONE.
- RD_ADDR: arvalid = 1 until arready, then RD_DATA.
- RD_DATA: rready = 1; on rvalid, capture rdata/rresp, go to DONE.
- DONE: rsp_valid[grant] = 1 for exactly one cycle; rsp_rdata/rsp_resp hold until the next completion; return to IDLE.
- No response backpressure: requesters must sample on rsp_valid.
- Minimum latency with zero-wait slave: grant at cycle 0, aw/w or ar valid at cycle 1, bvalid/rvalid sampled at cycle 2, rsp_valid at cycle 3. Next grant occurs at cycle 4 earliest (IDLE is entered at cycle 4).
- Addresses and data pass through unmodified; no alignment checks. SLVERR/DECERR are forwarded, not retried.
- A requester asserting req_valid while another is serviced waits; no starvation, since worst-case wait is NUM_REQ-1 transactions.
- m_axi outputs are registered (no combinational path from inputs to m_axi_*valid).

Decomposition:
- Package gpio_ctrl_pkg holds:
  - state enum
  - AXI resp constants OKAY = 2'b00, SLVERR = 2'b10
  - GPIO register offsets: GPIO_DATA 0x000, GPIO_TRI 0x004, GPIO2_DATA 0x008, GPIO2_TRI 0x00C
- Sub-module rr_arbiter (NUM_REQ): takes req vector and advance strobe, returns one-hot grant; owns the priority pointer.

Test Plan:
- Req0 writes 0x39AF1292 to 0x004; slave zero-wait -> req_ready[0] pulse, awaddr 0x004, wstrb 0xF, rsp_valid[0] at grant+3, rsp_resp 0, rsp_rdata 0.
- Req1 reads 0x004 after the above -> arvalid with araddr 0x004, rsp_valid[1], rsp_rdata 0x39AF1292, rsp_resp 0.
- Req0 and req1 both held continuously for 4 commands -> grant order 0,1,0,1 after reset; never the same requester twice in a row.
- Slave asserts awready 3 cycles before wready (and the reverse case) -> awvalid drops after its handshake, wvalid held, exactly one bready handshake, one rsp_valid.
- Slave delays rvalid 10 cycles and returns rresp 2'b10 -> rready held high throughout, rsp_resp 2'b10, no retry.
- Reset asserted one cycle after awvalid rises -> next cycle all m_axi valids 0, no rsp_valid; first grant after reset goes to requester 0.
